// File: rtl/uart_jogo_pkg.sv
// Shared types, constants and ASCII helpers for the game-status
// UART transmitter (uart_tx_jogo and its byte serializer).
package uart_jogo_pkg;

  typedef enum logic [3:0] {
    OCIOSO = 4'd0,
    INICIO = 4'd1,
    DADOS  = 4'd2,
    PARADA = 4'd3,
    FIM    = 4'd4
  } estado_t;

  typedef enum logic [1:0] {
    P_OCIOSO,
    P_ENVIO,
    P_FIM
  } fase_t;

  typedef struct packed {
    logic [3:0] macro;
    logic [3:0] micro;
    logic [3:0] estado;
    logic [1:0] res_macro;
    logic [1:0] res_jogo;
  } campos_t;

  localparam int PACOTE_BYTES = 6;
  localparam int CLKS_PER_BIT_PADRAO = 434;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic [7:0] hex_ascii(
    input logic [3:0] v
  );
    if (v < 4'd10)
      return ASCII_ZERO + {4'd0, v};
    return ASCII_A + {4'd0, v} - 8'd10;
  endfunction

  function automatic logic [7:0] flag_ascii(
    input logic [1:0] r
  );
    return ASCII_ZERO + {6'd0, r};
  endfunction

  function automatic logic [7:0] pacote_byte(
    input campos_t    c,
    input logic [2:0] i
  );
    logic [7:0] b;
    case (i)
      3'd0:    b = hex_ascii(c.macro);
      3'd1:    b = hex_ascii(c.micro);
      3'd2:    b = hex_ascii(c.estado);
      3'd3:    b = flag_ascii(c.res_macro);
      3'd4:    b = flag_ascii(c.res_jogo);
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_jogo_8n1.sv
// Single-byte 8N1 serializer, LSB first. A new byte offered at the
// last stop-bit cycle chains straight into the next start bit.
import uart_jogo_pkg::*;

module uart_tx_8n1 #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] dado,
  input  logic       partida,
  output logic       ocupado,
  output logic       feito,
  output logic       fim_quadro,
  output estado_t    fase,
  output logic       tx
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] ULT =
    CW'(CLKS_PER_BIT - 1);

  estado_t       st;
  logic [CW-1:0] cnt;
  logic [2:0]    nbit;
  logic [7:0]    sh;
  logic          fim_bit;

  assign fim_bit    = (cnt == ULT);
  assign fim_quadro = (st == PARADA) && fim_bit;
  assign ocupado    = (st != OCIOSO);
  assign fase       = st;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st    <= OCIOSO;
      tx    <= 1'b1;
      cnt   <= '0;
      nbit  <= '0;
      sh    <= '0;
      feito <= 1'b0;
    end else begin
      feito <= 1'b0;
      case (st)
        OCIOSO: begin
          if (partida) begin
            sh  <= dado;
            cnt <= '0;
            tx  <= 1'b0;
            st  <= INICIO;
          end
        end
        INICIO: begin
          if (fim_bit) begin
            cnt  <= '0;
            nbit <= '0;
            tx   <= sh[0];
            st   <= DADOS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DADOS: begin
          if (fim_bit) begin
            cnt <= '0;
            if (nbit == 3'd7) begin
              tx <= 1'b1;
              st <= PARADA;
            end else begin
              nbit <= nbit + 3'd1;
              sh   <= {1'b0, sh[7:1]};
              tx   <= sh[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARADA: begin
          if (fim_bit) begin
            cnt   <= '0;
            feito <= 1'b1;
            if (partida) begin
              sh <= dado;
              tx <= 1'b0;
              st <= INICIO;
            end else begin
              st <= OCIOSO;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          tx <= 1'b1;
          st <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_jogo.sv
// Game-status packet sender: snapshots the fields on request and
// streams six ASCII bytes back-to-back through the 8N1 serializer.
import uart_jogo_pkg::*;

module uart_tx_jogo #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enviar,
  input  logic [3:0] macro,
  input  logic [3:0] micro,
  input  logic [3:0] estado,
  input  logic [1:0] resultado_macro,
  input  logic [1:0] resultado_jogo,
  output logic       tx,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam logic [2:0] ULT_BYTE =
    3'(PACOTE_BYTES - 1);

  fase_t      fase;
  campos_t    snap;
  campos_t    vivo;
  logic [2:0] indice;
  logic [7:0] dado;
  logic       partida;
  logic       ser_ocupado;
  logic       feito;
  logic       fim_quadro;
  estado_t    ser_fase;

  assign vivo = {macro, micro, estado,
                 resultado_macro, resultado_jogo};

  // Byte 0 comes from the live fields on the accepting edge; later
  // bytes are offered on the last stop-bit cycle of the one before.
  assign partida =
    ((fase == P_OCIOSO) && enviar) ||
    ((fase == P_ENVIO) && fim_quadro &&
     (indice != ULT_BYTE));

  assign dado = (fase == P_OCIOSO)
    ? pacote_byte(vivo, 3'd0)
    : pacote_byte(snap, indice + 3'd1);

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clock      (clock),
    .reset      (reset),
    .dado       (dado),
    .partida    (partida),
    .ocupado    (ser_ocupado),
    .feito      (feito),
    .fim_quadro (fim_quadro),
    .fase       (ser_fase),
    .tx         (tx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fase   <= P_OCIOSO;
      snap   <= '0;
      indice <= '0;
    end else begin
      case (fase)
        P_OCIOSO: begin
          if (enviar) begin
            snap   <= vivo;
            indice <= '0;
            fase   <= P_ENVIO;
          end
        end
        P_ENVIO: begin
          if (fim_quadro && (indice == ULT_BYTE))
            fase <= P_FIM;
          else if (feito)
            indice <= indice + 3'd1;
        end
        P_FIM:   fase <= P_OCIOSO;
        default: fase <= P_OCIOSO;
      endcase
    end
  end

  assign ocupado = (fase == P_ENVIO) && ser_ocupado;
  assign pronto  = (fase == P_FIM);

  always_comb begin
    db_estado = OCIOSO;
    case (fase)
      P_ENVIO: db_estado = ser_fase;
      P_FIM:   db_estado = FIM;
      default: db_estado = OCIOSO;
    endcase
  end

endmodule
